pc_fetch_unit: RTL

- Program-counter register and instruction-fetch sequencer that consumes PCSrc from the jump decoder.
- Holds the architectural PC and issues one instruction-memory request at a time using a valid/ready request and a valid response.
- Presents the fetched instruction to decode/execute, and on execute acknowledge selects the next PC: sequential, branch/jal target, or jalr target.
- Sits between instruction memory and the controller/datapath.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/next_pc_sel.sv | 28 ++
 rtl/pc_fetch_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the fetch unit and the jump decoder.
//   XLEN                      default datapath / PC width
//   NOP                       addi x0,x0,0, the instruction register's reset value
//   RESET_VECTOR_DEF          default PC after reset
//   TRAP_VECTOR_DEF           default redirect for misaligned targets
//   OP_BRANCH/OP_JALR/OP_JAL  opcodes decoded by the jump decoder
//   fetch_state_e             fetch sequencer state encoding
package riscv_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational next-PC selection.
//   pc         current PC
//   pcsrc      redirect taken
//   jalr       1 = target is aluresult with bit 0 cleared, 0 = pctarget
//   pctarget   PC+imm
//   aluresult  rs1+imm
//   next_pc    PC+4 when not taken, otherwise the selected target
//   misaligned taken redirect whose target is not 4-byte aligned
module next_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pcsrc,
  input  logic            jalr,
  input  logic [XLEN-1:0] pctarget,
  input  logic [XLEN-1:0] aluresult,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);
  logic [XLEN-1:0] target;

  always_comb begin
    target     = jalr ? {aluresult[XLEN-1:1], 1'b0} : pctarget;
    // PC+4 wraps silently at the top of the address space
    next_pc    = pcsrc ? target : pc + XLEN'(4);
    misaligned = pcsrc && (target[1:0] != 2'b00);
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register and non-pipelined fetch sequencer.
// One instruction memory request at a time: REQ (request out) -> WAIT (await
// response) -> HOLD (instruction presented until execute acknowledges).
//   clk, reset                 clock, async active-high reset
//   PCSrc, Jalr                redirect select, sampled only on InstrAck in HOLD
//   PCTarget, ALUResult        branch/jal and jalr targets
//   ImemReqValid/Ready, Addr   fetch request handshake (Addr = PC)
//   ImemRspValid, ImemRdata    fetch response
//   InstrValid, Instr, PC      fetched instruction and its address
//   PCPlus4                    PC+4 (combinational)
//   InstrAck                   execute retired Instr this cycle
//   MisalignTrap, TrapAddr     only with RV_MISALIGN_TRAP_EN: one-cycle trap
//                              pulse and the faulting target
// Build option: RV_MISALIGN_TRAP_EN redirects misaligned taken targets to
// TRAP_VECTOR instead of following them.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN         = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(riscv_pkg::RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(riscv_pkg::TRAP_VECTOR_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrc,
  input  logic            Jalr,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  output logic            ImemReqValid,
  input  logic            ImemReqReady,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemRspValid,
  input  logic [31:0]     ImemRdata,
  output logic            InstrValid,
  output logic [31:0]     Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
`ifdef RV_MISALIGN_TRAP_EN
  output logic            MisalignTrap,
  output logic [XLEN-1:0] TrapAddr,
`endif
  input  logic            InstrAck
);
  fetch_state_e    state, state_d;
  logic            req_valid_d, instr_valid_d;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d, next_pc;
  logic            misaligned;

  next_pc_sel #(.XLEN(XLEN)) u_sel (
    .pc        (PC),
    .pcsrc     (PCSrc),
    .jalr      (Jalr),
    .pctarget  (PCTarget),
    .aluresult (ALUResult),
    .next_pc   (next_pc),
    .misaligned(misaligned)
  );

  assign ImemAddr = PC;
  assign PCPlus4  = PC + XLEN'(4);

`ifdef RV_MISALIGN_TRAP_EN
  logic            trap_d;
  logic [XLEN-1:0] trap_addr_d;
`else
  // trap-only signals have no consumer in this build
  logic unused_trap;
  assign unused_trap = ^{misaligned, TRAP_VECTOR};
`endif

  always_comb begin
    state_d       = state;
    req_valid_d   = 1'b0;
    instr_valid_d = InstrValid;
    instr_d       = Instr;
    pc_d          = PC;
`ifdef RV_MISALIGN_TRAP_EN
    trap_d        = 1'b0;
    trap_addr_d   = TrapAddr;
`endif
    case (state)
      FS_REQ: begin
        // valid rises the cycle after reset release and holds until accepted
        req_valid_d = 1'b1;
        if (ImemReqValid && ImemReqReady) begin
          state_d     = FS_WAIT;
          req_valid_d = 1'b0;
        end
      end
      FS_WAIT: begin
        if (ImemRspValid) begin
          instr_d       = ImemRdata;
          instr_valid_d = 1'b1;
          state_d       = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (InstrAck) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          req_valid_d   = 1'b1;
          state_d       = FS_REQ;
`ifdef RV_MISALIGN_TRAP_EN
          if (misaligned) begin
            pc_d        = TRAP_VECTOR;
            trap_d      = 1'b1;
            trap_addr_d = next_pc;
          end
`endif
        end
      end
      default: state_d = FS_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FS_REQ;
      ImemReqValid <= 1'b0;
      InstrValid   <= 1'b0;
      Instr        <= NOP;
      PC           <= RESET_VECTOR;
`ifdef RV_MISALIGN_TRAP_EN
      MisalignTrap <= 1'b0;
      TrapAddr     <= '0;
`endif
    end else begin
      state        <= state_d;
      ImemReqValid <= req_valid_d;
      InstrValid   <= instr_valid_d;
      Instr        <= instr_d;
      PC           <= pc_d;
`ifdef RV_MISALIGN_TRAP_EN
      MisalignTrap <= trap_d;
      TrapAddr     <= trap_addr_d;
`endif
    end
  end
endmodule
